// File: rtl/data_mem_lsu_if.sv
// Word-wide data memory bus between the load/store unit (master) and memory (slave).
// Request fields are held stable by the master until the edge where bus_ready is high.
interface data_mem_lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Load/store unit: byte-lane alignment, write strobes and load extension over a req/ready bus.
// Define LSU_MISALIGN_EN to split word-crossing accesses into two bus transactions.
module data_mem_lsu (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_re_i,
    input  logic               mem_we_i,
    input  logic [2:0]         data_mem_opr_i,
    input  logic [3:0]         data_mem_opw_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               stall_o,
    output logic               done_o,
    output logic               err_o,
    data_mem_lsu_if.master     bus
);

    typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;

    state_t      state_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_wstrb_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        err_q;
    logic        we_q;
    logic [1:0]  off_q;
    logic [2:0]  opr_q;

    logic [3:0]  size_mask_s;
    logic        legal_s;
    logic        half_s;
    logic        word_s;
    logic        misalign_s;
    logic        go_bus_s;
    logic [31:0] ld_word_s;
    logic [31:0] ld_result_s;

`ifdef LSU_MISALIGN_EN
    logic        split_q;
    logic [31:0] addr2_q;
    logic [3:0]  wstrb_hi_q;
    logic [31:0] wdata_hi_q;
    logic [31:0] word_lo_q;
    logic [7:0]  lane_s;
    logic [63:0] wide_wdata_s;
    logic [31:0] first_word_s;
`else
    logic [3:0]  lane_s;
    logic [31:0] wide_wdata_s;
`endif

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] opr);
        logic [31:0] r;
        case (opr[1:0])
            2'b00:   r = opr[2] ? {24'h000000, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            2'b01:   r = opr[2] ? {16'h0000, w[15:0]}   : {{16{w[15]}}, w[15:0]};
            2'b10:   r = w;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Decode size and legality of the request currently presented by the core.
    always_comb begin
        size_mask_s = 4'b0000;
        legal_s     = 1'b0;
        if (mem_we_i) begin
            size_mask_s = data_mem_opw_i;
            case (data_mem_opw_i)
                4'b0001, 4'b0011, 4'b1111: legal_s = 1'b1;
                default:                   legal_s = 1'b0;
            endcase
        end else begin
            case (data_mem_opr_i)
                3'b000, 3'b100: begin size_mask_s = 4'b0001; legal_s = 1'b1; end
                3'b001, 3'b101: begin size_mask_s = 4'b0011; legal_s = 1'b1; end
                3'b010:         begin size_mask_s = 4'b1111; legal_s = 1'b1; end
                default:        begin size_mask_s = 4'b0000; legal_s = 1'b0; end
            endcase
        end
        half_s     = (size_mask_s == 4'b0011);
        word_s     = (size_mask_s == 4'b1111);
        misalign_s = (half_s & addr_i[0]) | (word_s & (addr_i[1:0] != 2'b00));
`ifdef LSU_MISALIGN_EN
        go_bus_s   = legal_s;
`else
        go_bus_s   = legal_s & ~misalign_s;
`endif
    end

`ifdef LSU_MISALIGN_EN
    assign lane_s       = {4'b0000, size_mask_s} << addr_i[1:0];
    assign wide_wdata_s = {32'h0000_0000, wdata_i} << {addr_i[1:0], 3'b000};
    // In ACC0 the word is used on its own; bytes of a non-split access never reach the upper half.
    assign first_word_s = (state_q == S_ACC1) ? word_lo_q : bus.bus_rdata;
    assign ld_word_s    = 32'({bus.bus_rdata, first_word_s} >> {off_q, 3'b000});
`else
    assign lane_s       = size_mask_s << addr_i[1:0];
    assign wide_wdata_s = wdata_i << {addr_i[1:0], 3'b000};
    assign ld_word_s    = bus.bus_rdata >> {off_q, 3'b000};
`endif

    assign ld_result_s = we_q ? 32'h0000_0000 : load_ext(ld_word_s, opr_q);
    assign stall_o     = (mem_re_i | mem_we_i) & (state_q != S_RESP);

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_wstrb_q <= 4'b0000;
            bus_wdata_q <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            off_q       <= 2'b00;
            opr_q       <= 3'b000;
`ifdef LSU_MISALIGN_EN
            split_q     <= 1'b0;
            addr2_q     <= 32'h0000_0000;
            wstrb_hi_q  <= 4'b0000;
            wdata_hi_q  <= 32'h0000_0000;
            word_lo_q   <= 32'h0000_0000;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_re_i | mem_we_i) begin
                        we_q  <= mem_we_i;
                        off_q <= addr_i[1:0];
                        opr_q <= data_mem_opr_i;
                        if (go_bus_s) begin
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= mem_we_i;
                            bus_addr_q  <= {addr_i[31:2], 2'b00};
                            bus_wstrb_q <= mem_we_i ? lane_s[3:0] : 4'b0000;
                            bus_wdata_q <= mem_we_i ? wide_wdata_s[31:0] : 32'h0000_0000;
`ifdef LSU_MISALIGN_EN
                            split_q     <= |lane_s[7:4];
                            addr2_q     <= {addr_i[31:2], 2'b00} + 32'd4;
                            wstrb_hi_q  <= mem_we_i ? lane_s[7:4] : 4'b0000;
                            wdata_hi_q  <= mem_we_i ? wide_wdata_s[63:32] : 32'h0000_0000;
`endif
                            state_q     <= S_ACC0;
                        end else begin
                            rdata_q <= 32'h0000_0000;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= S_RESP;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ACC0: begin
                    if (bus.bus_ready) begin
`ifdef LSU_MISALIGN_EN
                        if (split_q) begin
                            word_lo_q   <= bus.bus_rdata;
                            bus_addr_q  <= addr2_q;
                            bus_wstrb_q <= wstrb_hi_q;
                            bus_wdata_q <= wdata_hi_q;
                            state_q     <= S_ACC1;
                        end else begin
                            bus_req_q <= 1'b0;
                            rdata_q   <= ld_result_s;
                            done_q    <= 1'b1;
                            err_q     <= 1'b0;
                            state_q   <= S_RESP;
                        end
`else
                        bus_req_q <= 1'b0;
                        rdata_q   <= ld_result_s;
                        done_q    <= 1'b1;
                        err_q     <= 1'b0;
                        state_q   <= S_RESP;
`endif
                    end else begin
                        state_q <= S_ACC0;
                    end
                end
                S_ACC1: begin
`ifdef LSU_MISALIGN_EN
                    if (bus.bus_ready) begin
                        bus_req_q <= 1'b0;
                        rdata_q   <= ld_result_s;
                        done_q    <= 1'b1;
                        err_q     <= 1'b0;
                        state_q   <= S_RESP;
                    end else begin
                        state_q <= S_ACC1;
                    end
`else
                    bus_req_q <= 1'b0;
                    state_q   <= S_IDLE;
`endif
                end
                S_RESP: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    bus_req_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wstrb = bus_wstrb_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign rdata_o       = rdata_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: vector table of single accesses plus reset and split sequences.
// Split-access vectors are selected when LSU_MISALIGN_EN is defined.
module tb_data_mem_lsu;

    logic        clk;
    logic        rst;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  opr;
    logic [3:0]  opw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    int cur   = 0;

    data_mem_lsu_if bus_if ();

    data_mem_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .mem_re_i       (mem_re),
        .mem_we_i       (mem_we),
        .data_mem_opr_i (opr),
        .data_mem_opw_i (opw),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .rdata_o        (rdata),
        .stall_o        (stall),
        .done_o         (done),
        .err_o          (err),
        .bus            (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        re;
        logic        we;
        logic [2:0]  opr;
        logic [3:0]  opw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word0;
        logic [31:0] word1;
        int          waits;
        logic        bus;
        logic        split;
        logic [31:0] a0;
        logic [3:0]  s0;
        logic [31:0] d0;
        logic [31:0] a1;
        logic [3:0]  s1;
        logic [31:0] d1;
        logic        bwe;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[24];
    int   nv = 0;

    function automatic vec_t mk(input logic re, input logic we, input logic [2:0] o_r,
                                input logic [3:0] o_w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] w0, input int ws, input logic b,
                                input logic [31:0] ea, input logic [3:0] es, input logic [31:0] ed,
                                input logic ewe, input logic [31:0] er, input logic ee);
        vec_t v;
        v.re = re; v.we = we; v.opr = o_r; v.opw = o_w; v.addr = a; v.wdata = wd;
        v.word0 = w0; v.word1 = 32'h0; v.waits = ws; v.bus = b; v.split = 1'b0;
        v.a0 = ea; v.s0 = es; v.d0 = ed; v.a1 = 32'h0; v.s1 = 4'h0; v.d1 = 32'h0;
        v.bwe = ewe; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d actual=%h required=%h", nm, cur, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  cyc;
        int  waits;
        int  phase;
        int  exp_lat;
        bit  hs;
        bit  fin;
        @(negedge clk);
        mem_re = v.re; mem_we = v.we; opr = v.opr; opw = v.opw;
        addr = v.addr; wdata = v.wdata; bus_if.bus_ready = 1'b0;
        #1 chk("stall_req", {31'b0, stall}, 32'd1);
        waits = v.waits; phase = 0; hs = 1'b0; fin = 1'b0; cyc = 0;
        exp_lat = v.bus ? ((v.split ? 2 : 1) * (v.waits + 1) + 1) : 1;
        while (!fin && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                fin = 1'b1;
                chk("latency", cyc, exp_lat);
                chk("err", {31'b0, err}, {31'b0, v.exp_err});
                chk("rdata", rdata, v.exp_rdata);
                chk("stall_done", {31'b0, stall}, 32'd0);
                chk("req_done", {31'b0, bus_if.bus_req}, 32'd0);
                mem_re = 1'b0; mem_we = 1'b0; bus_if.bus_ready = 1'b0;
            end else begin
                if (hs) begin phase = 1; hs = 1'b0; waits = v.waits; end
                if (bus_if.bus_req) begin
                    chk("expect_bus", {31'b0, v.bus}, 32'd1);
                    chk("bus_we", {31'b0, bus_if.bus_we}, {31'b0, v.bwe});
                    chk("bus_addr", bus_if.bus_addr, phase == 1 ? v.a1 : v.a0);
                    chk("bus_wstrb", {28'b0, bus_if.bus_wstrb}, {28'b0, (phase == 1 ? v.s1 : v.s0)});
                    chk("bus_wdata", bus_if.bus_wdata, phase == 1 ? v.d1 : v.d0);
                    if (waits > 0) begin
                        bus_if.bus_ready = 1'b0;
                        waits--;
                    end else begin
                        bus_if.bus_ready = 1'b1;
                        bus_if.bus_rdata = (phase == 1) ? v.word1 : v.word0;
                        hs = 1'b1;
                    end
                end else begin
                    bus_if.bus_ready = 1'b0;
                    chk("bus_req_missing", {31'b0, bus_if.bus_req}, 32'd1);
                end
            end
        end
        if (!fin) chk("timeout_done", 32'd0, 32'd1);
        @(negedge clk);
        chk("done_pulse", {31'b0, done}, 32'd0);
        chk("err_pulse", {31'b0, err}, 32'd0);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; mem_re = 1'b0; mem_we = 1'b0; opr = 3'b000; opw = 4'b0000;
        addr = 32'h0; wdata = 32'h0;
        bus_if.bus_ready = 1'b0; bus_if.bus_rdata = 32'h0;

        vecs[nv++] = mk(1, 0, 3'b010, 4'h0, 32'h0000_0100, 32'h0, 32'h8000_00F0, 0, 1, 32'h0000_0100, 4'b0000, 32'h0, 0, 32'h8000_00F0, 0);
        vecs[nv++] = mk(1, 0, 3'b000, 4'h0, 32'h0000_0103, 32'h0, 32'h8000_0000, 0, 1, 32'h0000_0100, 4'b0000, 32'h0, 0, 32'hFFFF_FF80, 0);
        vecs[nv++] = mk(1, 0, 3'b100, 4'h0, 32'h0000_0103, 32'h0, 32'h8000_0000, 0, 1, 32'h0000_0100, 4'b0000, 32'h0, 0, 32'h0000_0080, 0);
        vecs[nv++] = mk(1, 0, 3'b001, 4'h0, 32'h0000_0102, 32'h0, 32'h8001_1234, 0, 1, 32'h0000_0100, 4'b0000, 32'h0, 0, 32'hFFFF_8001, 0);
        vecs[nv++] = mk(1, 0, 3'b101, 4'h0, 32'h0000_0102, 32'h0, 32'h8001_1234, 0, 1, 32'h0000_0100, 4'b0000, 32'h0, 0, 32'h0000_8001, 0);
        vecs[nv++] = mk(1, 0, 3'b001, 4'h0, 32'h0000_0100, 32'h0, 32'h8001_1234, 0, 1, 32'h0000_0100, 4'b0000, 32'h0, 0, 32'h0000_1234, 0);
        vecs[nv++] = mk(1, 0, 3'b000, 4'h0, 32'h0000_0101, 32'h0, 32'h0000_7F00, 0, 1, 32'h0000_0100, 4'b0000, 32'h0, 0, 32'h0000_007F, 0);
        vecs[nv++] = mk(0, 1, 3'b000, 4'b0011, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 3, 1, 32'h0000_0100, 4'b1100, 32'hABCD_0000, 1, 32'h0, 0);
        vecs[nv++] = mk(0, 1, 3'b000, 4'b0001, 32'h0000_0201, 32'h0000_00A5, 32'h0, 0, 1, 32'h0000_0200, 4'b0010, 32'h0000_A500, 1, 32'h0, 0);
        vecs[nv++] = mk(0, 1, 3'b000, 4'b1111, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0, 1, 1, 32'h0000_0300, 4'b1111, 32'hDEAD_BEEF, 1, 32'h0, 0);
        vecs[nv++] = mk(1, 0, 3'b011, 4'h0, 32'h0000_0100, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1);
        vecs[nv++] = mk(0, 1, 3'b000, 4'b0010, 32'h0000_0100, 32'h5555_5555, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1);
        vecs[nv++] = mk(1, 1, 3'b010, 4'b0001, 32'h0000_0403, 32'h0000_005A, 32'h0, 0, 1, 32'h0000_0400, 4'b1000, 32'h5A00_0000, 1, 32'h0, 0);
        vecs[nv++] = mk(1, 0, 3'b100, 4'h0, 32'hFFFF_FFFE, 32'h0, 32'h00AB_0000, 2, 1, 32'hFFFF_FFFC, 4'b0000, 32'h0, 0, 32'h0000_00AB, 0);
`ifdef LSU_MISALIGN_EN
        v = mk(0, 1, 3'b000, 4'b1111, 32'h0FFF_FFFD, 32'hAABB_CCDD, 32'h0, 0, 1, 32'h0FFF_FFFC, 4'b1110, 32'hBBCC_DD00, 1, 32'h0, 0);
        v.split = 1'b1; v.a1 = 32'h1000_0000; v.s1 = 4'b0001; v.d1 = 32'h0000_00AA;
        vecs[nv++] = v;
        v = mk(1, 0, 3'b010, 4'h0, 32'h0FFF_FFFE, 32'h0, 32'hBEEF_0000, 1, 1, 32'h0FFF_FFFC, 4'b0000, 32'h0, 0, 32'hDEAD_BEEF, 0);
        v.split = 1'b1; v.a1 = 32'h1000_0000; v.word1 = 32'h0000_DEAD;
        vecs[nv++] = v;
        v = mk(1, 0, 3'b010, 4'h0, 32'hFFFF_FFFF, 32'h0, 32'h1100_0000, 0, 1, 32'hFFFF_FFFC, 4'b0000, 32'h0, 0, 32'h4433_2211, 0);
        v.split = 1'b1; v.a1 = 32'h0000_0000; v.word1 = 32'h0044_3322;
        vecs[nv++] = v;
        vecs[nv++] = mk(1, 0, 3'b001, 4'h0, 32'h0000_0101, 32'h0, 32'h00CD_AB00, 0, 1, 32'h0000_0100, 4'b0000, 32'h0, 0, 32'hFFFF_CDAB, 0);
`else
        vecs[nv++] = mk(0, 1, 3'b000, 4'b1111, 32'h0FFF_FFFD, 32'hAABB_CCDD, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1);
        vecs[nv++] = mk(1, 0, 3'b010, 4'h0, 32'h0000_0102, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1);
        vecs[nv++] = mk(1, 0, 3'b001, 4'h0, 32'h0000_0101, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1);
`endif

        // Reset values while rst is held.
        #12;
        cur = -1;
        chk("rst_bus_req", {31'b0, bus_if.bus_req}, 32'd0);
        chk("rst_bus_we", {31'b0, bus_if.bus_we}, 32'd0);
        chk("rst_bus_addr", bus_if.bus_addr, 32'd0);
        chk("rst_bus_wstrb", {28'b0, bus_if.bus_wstrb}, 32'd0);
        chk("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < nv; i++) begin
            cur = i;
            run_vec(vecs[i]);
        end

        // Reset in the middle of ACC0 aborts the transaction immediately.
        cur = 100;
        @(negedge clk);
        mem_re = 1'b1; mem_we = 1'b0; opr = 3'b010; addr = 32'h0000_0500;
        bus_if.bus_ready = 1'b0;
        @(negedge clk);
        chk("acc0_req", {31'b0, bus_if.bus_req}, 32'd1);
        chk("acc0_addr", bus_if.bus_addr, 32'h0000_0500);
        #2 rst = 1'b1;
        #1;
        chk("abort_req", {31'b0, bus_if.bus_req}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        mem_re = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req", {31'b0, bus_if.bus_req}, 32'd0);
        cur = 101;
        run_vec(mk(1, 0, 3'b010, 4'h0, 32'h0000_0104, 32'h0, 32'h0BAD_F00D, 0, 1, 32'h0000_0104, 4'b0000, 32'h0, 0, 32'h0BAD_F00D, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
